// File: rtl/mem_ack_responder_pkg.sv
// mem_ack_responder_pkg: FSM encoding and fixed widths shared by the memory responder files
package mem_ack_responder_pkg;
    localparam int MEM_WORD_BITS = 32;
    localparam int LATENCY_CNT_W = 4;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;
endpackage

// File: rtl/mem_ack_responder_if.sv
// mem_ack_responder_if: cs/we/addr/data/ack word bus between a cache (master) and memory (slave)
interface mem_ack_responder_if
    import mem_ack_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                     cs;
    logic                     we;
    logic [MEM_WORD_BITS-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     ack;
    modport master (output cs, we, addr, wdata, input rdata, ack);
    modport slave  (input cs, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_ack_responder_mem_array.sv
// mem_ack_responder_mem_array: single-port synchronous word RAM, write-first, no reset
module mem_ack_responder_mem_array #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    // dout only moves on reads so the last read word stays visible across writes
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= din;
        if (re) dout <= we ? din : mem[idx];
    end
endmodule

// File: rtl/mem_ack_responder.sv
// mem_ack_responder: fixed-latency memory responder with one-cycle ack pulses.
// Define MEM_STATS_EN to add the rd_count/wr_count access counters.
module mem_ack_responder
    import mem_ack_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MEM_STATS_EN
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
`endif
    mem_ack_responder_if.slave bus
);
    state_e                  state_q, state_d;
    logic [LATENCY_CNT_W-1:0] cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    ack_q, ack_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    cap, fire;
    logic [DATA_WIDTH-1:0]   ram_dout;
    logic                    unused_addr;
`ifdef MEM_STATS_EN
    logic [31:0]             rd_count_q, rd_count_d, wr_count_q, wr_count_d;
`endif
    assign unused_addr = ^{bus.addr[MEM_WORD_BITS-1:ADDR_WIDTH+2], bus.addr[1:0]};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        fire    = 1'b0;
        case (state_q)
            S_IDLE: cap = bus.cs;
            S_WAIT: begin
                fire    = cnt_q == '0;
                cnt_d   = fire ? cnt_q : cnt_q - 1'b1;
                state_d = fire ? S_ACK : S_WAIT;
            end
            S_ACK: begin
                cap     = bus.cs;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (cap) begin
            state_d = S_WAIT;
            cnt_d   = LATENCY_CNT_W'(LATENCY - 1);
        end
        ack_d      = fire;
        we_d       = cap ? bus.we : we_q;
        idx_d      = cap ? bus.addr[ADDR_WIDTH+1:2] : idx_q;
        wdata_d    = cap ? bus.wdata : wdata_q;
        rd_valid_d = rd_valid_q | (fire & ~we_q);
`ifdef MEM_STATS_EN
        rd_count_d = rd_count_q + 32'(fire & ~we_q);
        wr_count_d = wr_count_q + 32'(fire & we_q);
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            ack_q      <= 1'b0;
            rd_valid_q <= 1'b0;
`ifdef MEM_STATS_EN
            rd_count_q <= '0;
            wr_count_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            rd_valid_q <= rd_valid_d;
`ifdef MEM_STATS_EN
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
`endif
        end
    end
    mem_ack_responder_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk (clk),
        .we  (fire & we_q),
        .re  (fire & ~we_q),
        .idx (idx_q),
        .din (wdata_q),
        .dout(ram_dout)
    );
    // RAM output is unreset, so hide it until the first read has landed
    assign bus.rdata = rd_valid_q ? ram_dout : '0;
    assign bus.ack   = ack_q;
`ifdef MEM_STATS_EN
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_mem_ack_responder.sv
// tb_mem_ack_responder: directed and randomized traffic checked against a queue/array model
module tb_mem_ack_responder;
    localparam int AW = 10, DW = 32, LAT = 4, DEPTH = 1 << AW;
    typedef struct {
        int          due;
        bit          we;
        int          idx;
        logic [31:0] d;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          pass_cnt = 0, total = 0, cyc = 0;
    exp_t        pend[$];
    logic [31:0] model[DEPTH];
    logic [31:0] last_rd = '0;
    logic [31:0] r;
    int          l, t0;
    mem_ack_responder_if #(.DATA_WIDTH(DW)) bus();
`ifdef MEM_STATS_EN
    logic [31:0] rd_count, wr_count;
    int          exp_rd = 0, exp_wr = 0;
`endif
    mem_ack_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef MEM_STATS_EN
        .rd_count(rd_count),
        .wr_count(wr_count),
`endif
        .bus     (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask
    // The model: each captured request completes exactly LAT cycles after capture, in order
    always @(negedge clk) begin
        bit   exp_ack;
        exp_t e;
        if (!rst) begin
            exp_ack = pend.size() > 0 && pend[0].due == cyc;
            chk("ack", 32'(bus.ack), 32'(exp_ack));
            if (exp_ack) begin
                e = pend.pop_front();
                if (e.we) begin
                    model[e.idx] = e.d;
`ifdef MEM_STATS_EN
                    exp_wr++;
`endif
                end else begin
                    last_rd = model[e.idx];
`ifdef MEM_STATS_EN
                    exp_rd++;
`endif
                end
            end
            chk("rdata", bus.rdata, last_rd);
`ifdef MEM_STATS_EN
            chk("rd_count", rd_count, exp_rd);
            chk("wr_count", wr_count, exp_wr);
`endif
        end
    end
    task automatic idle(int n);
        bus.cs = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic txn(bit we, logic [31:0] addr, logic [31:0] d, bit drop,
                       output logic [31:0] rd, output int lat);
        exp_t e;
        bus.cs    = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = d;
        @(posedge clk);
        #1;
        e.due = cyc + LAT;
        e.we  = we;
        e.idx = int'(addr[AW+1:2]);
        e.d   = d;
        pend.push_back(e);
        if (drop) begin
            bus.cs    = 1'b0;
            bus.we    = 1'($urandom);
            bus.addr  = $urandom;
            bus.wdata = $urandom;
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.ack && lat < 20);
        rd = bus.rdata;
        chk("latency", 32'(lat), 32'(LAT));
    endtask
    task automatic reset_now();
        rst = 1'b1;
        #1;
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_data", bus.rdata, 32'd0);
        pend.delete();
        last_rd = '0;
`ifdef MEM_STATS_EN
        chk("rst_rd_count", rd_count, 32'd0);
        chk("rst_wr_count", wr_count, 32'd0);
        exp_rd = 0;
        exp_wr = 0;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        chk("idle_ack", 32'(bus.ack), 32'd0);
        chk("idle_data", bus.rdata, 32'd0);
        txn(1'b1, 32'h40, 32'hDEADBEEF, 1'b0, r, l);
        idle(2);
        txn(1'b0, 32'h40, 32'h0, 1'b0, r, l);
        chk("rd_40", r, 32'hDEADBEEF);
        chk("lat_lit", 32'(l), 32'd4);
        idle(1);
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 32'h100 + 32'(4 * i), 32'((i + 1) * 'h11), 1'b0, r, l);
            chk("burst_wr_period", 32'(cyc - t0), 32'(i == 0 ? 5 : 5 * (i + 1)));
        end
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, 32'h100 + 32'(4 * i), 32'h0, 1'b0, r, l);
            chk("burst_rd_data", r, 32'((i + 1) * 'h11));
            chk("burst_rd_period", 32'(cyc - t0), 32'(5 * (i + 1)));
        end
        idle(1);
        txn(1'b1, 32'h0, 32'hCAFE0001, 1'b0, r, l);
        txn(1'b1, 32'(4 << AW), 32'hCAFE0002, 1'b0, r, l);
        txn(1'b0, 32'h0, 32'h0, 1'b0, r, l);
        chk("alias", r, 32'hCAFE0002);
        txn(1'b1, 32'h8, 32'hA5A5A5A5, 1'b1, r, l);
        idle(3);
        txn(1'b0, 32'h8, 32'h0, 1'b0, r, l);
        chk("drop_cs", r, 32'hA5A5A5A5);
        idle(1);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 32'h40; bus.wdata = 32'h12345678;
        @(posedge clk);
        #1;
        bus.cs = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_now();
        txn(1'b0, 32'h40, 32'h0, 1'b0, r, l);
        chk("rst_word_kept", r, 32'hDEADBEEF);
        txn(1'b0, 32'h8, 32'h0, 1'b0, r, l);
        txn(1'b1, 32'h200, 32'h77, 1'b0, r, l);
        txn(1'b0, 32'h0, 32'h0, 1'b0, r, l);
        txn(1'b1, 32'h204, 32'h88, 1'b0, r, l);
        idle(1);
`ifdef MEM_STATS_EN
        chk("stats_rd", rd_count, 32'd3);
        chk("stats_wr", wr_count, 32'd2);
`endif
        for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(4 * i), $urandom, 1'b0, r, l);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            txn(1'($urandom), $urandom, $urandom, $urandom_range(0, 3) == 0, r, l);
        end
        idle(3);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
